effects_pipeline_mc: RTL and testbench
======================================

// Module: effects_pipeline_mc
// PURPOSE
//  Multi-channel successor of the single-channel effects pipeline. Takes time-multiplexed
//  ADC samples tagged with a channel index and applies a per-channel gain with saturation.
//  Then applies a selectable output stage: bypass, gain-only or hard clip.
//  Emits signed fixed-point samples through a valid/ready pipeline toward the DAC/output
//  formatter. Adds per-channel sticky saturation flags for the control CPU.
// PARAMETERS
//  bits_per_level      12  ADC sample width, unsigned offset-binary
//  bits_per_gain_frac  4   fractional bits of the unsigned gain word
//  gain_bits           11  total gain word width
//  fxp_size            16  output width, signed Q1.(fxp_size-1); must be >= bits_per_level
//  channels            2   number of channels (>=1); CW = max(1,$clog2(channels))
// PORTS
//  clk         in   1           clock, rising edge
//  rst         in   1           asynchronous reset, active-low
//  i_valid     in   1           input sample valid
//  o_ready     out  1           pipeline accepts input this cycle
//  i_channel   in   CW          channel tag of i_sample
//  i_sample    in   bits_per_level  ADC sample
//  o_valid     out  1           output sample valid
//  i_ready     in   1           downstream accepts output
//  o_channel   out  CW          channel tag of o_sample
//  o_sample    out  fxp_size    processed sample, two's complement
//  i_cfg_we    in   1           gain table write strobe
//  i_cfg_ch    in   CW          channel written
//  i_cfg_gain  in   gain_bits   new gain value
//  i_mode      in   2           0 bypass, 1 gain, 2 gain+hard clip, 3 reserved (= mode 1)
//  i_clip_thr  in   fxp_size-1  clip magnitude, unsigned
//  i_sat_clr   in   1           clears all sticky flags
//  o_sat       out  channels    sticky per-channel saturation/clip flags
// BEHAVIOUR
//  - Reset (rst=0): all stage valids 0, o_valid=0, o_sample=0, o_channel=0, o_sat=0.
//    Every gain entry = 1.0 (1<<bits_per_gain_frac). o_ready = 1 immediately after reset.
//  - Pipeline: 3 stages, global enable en = !o_valid | i_ready; o_ready = en.
//    Transfer occurs on i_valid & o_ready. Latency 3 cycles when i_ready held high.
//    Throughput 1 sample/cycle. When en=0 all stages, o_sample and o_channel hold stable.
//  - S1 (capture):
//    - s = {~msb, rest} of i_sample, then << (fxp_size-bits_per_level).
//    - Latch i_mode and i_clip_thr, and read gain[i_channel].
//    - Out-of-range i_channel (>= channels) is processed with gain 1.0 and its o_sat update is dropped.
//  - S2 (multiply): p = s * $signed({1'b0,gain}), full width fxp_size+gain_bits+1.
//    Then arithmetic >>> bits_per_gain_frac (truncate toward -inf).
//  - S3 (shape):
//    - Saturate p to [-2^(fxp_size-1), 2^(fxp_size-1)-1].
//    - Mode 2 additionally clamps to [-thr, +thr].
//    - Mode 0 outputs s unchanged; gain is ignored and no flag is set.
//    - Any clamp sets o_sat[ch] when the sample transfers into the output register.
//  - Config: i_cfg_we writes gain[i_cfg_ch] at the clock edge; writes are legal while stalled.
//    A sample accepted in the same cycle as a write to its channel uses the OLD gain.
//    i_cfg_ch >= channels: write ignored.
//  - Mode/threshold are latched per sample in S1, so mid-stream changes never split a sample.
//  - i_sat_clr with a simultaneous new saturation event: the set wins for that channel.
//  - Reset mid-stream: in-flight samples discarded, no partial output.
// TESTING
//  1. ch0 gain 1.0, mode 1, i_sample 0x800 / 0xC00 / 0x000
//     -> o_sample 0x0000 / 0x4000 / 0x8000 after 3 cycles; o_sat=0.
//  2. ch1 gain 0x020 (2.0), i_sample 0xC00 on ch1 -> 0x7FFF, o_sat=2'b10.
//     Then i_sat_clr -> o_sat=0.
//  3. mode 2, thr 0x2000, gain 1.0: 0xC00 -> 0x2000, 0x400 -> 0xE000, 0x900 -> 0x1000 (unclipped).
//  4. Stream 8 samples alternating ch0/ch1; hold i_ready=0 for 4 cycles mid-stream.
//     -> o_ready=0 while stalled, outputs held stable, no loss or duplication, order preserved.
//  5. cfg write ch0 gain 0x008 in the same cycle as a ch0 sample 0xC00
//     -> that sample gives 0x4000, the next gives 0x2000.
//  6. Drop rst for 1 cycle with 3 samples in flight
//     -> o_valid=0 at once, gains back to 1.0, no stale output afterwards.

Source files
------------

// File: rtl/effects_pipeline_mc.sv
// Multi-channel effects pipeline: per-channel gain with saturation, then a selectable
// output stage (bypass / gain / gain + hard clip), with sticky per-channel clamp flags.
module effects_pipeline_mc #(
  parameter int bits_per_level     = 12,
  parameter int bits_per_gain_frac = 4,
  parameter int gain_bits          = 11,
  parameter int fxp_size           = 16,
  parameter int channels           = 2,
  localparam int CW = (channels > 1) ? $clog2(channels) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [CW-1:0]             i_channel,
  input  logic [bits_per_level-1:0] i_sample,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [CW-1:0]             o_channel,
  output logic [fxp_size-1:0]       o_sample,
  input  logic                      i_cfg_we,
  input  logic [CW-1:0]             i_cfg_ch,
  input  logic [gain_bits-1:0]      i_cfg_gain,
  input  logic [1:0]                i_mode,
  input  logic [fxp_size-2:0]       i_clip_thr,
  input  logic                      i_sat_clr,
  output logic [channels-1:0]       o_sat
);

  localparam int PW = fxp_size + gain_bits + 1;
  localparam logic [gain_bits-1:0] GAIN_ONE = gain_bits'(1 << bits_per_gain_frac);
  localparam logic signed [fxp_size-1:0] MAX_F = {1'b0, {(fxp_size-1){1'b1}}};
  localparam logic signed [fxp_size-1:0] MIN_F = {1'b1, {(fxp_size-1){1'b0}}};
  localparam logic signed [PW-1:0] P_MAX = PW'(MAX_F);
  localparam logic signed [PW-1:0] P_MIN = ~P_MAX;

  logic en;
  logic [gain_bits-1:0] gain_q [channels];

  logic                       s1_valid_q, s1_chok_q;
  logic [CW-1:0]              s1_ch_q;
  logic signed [fxp_size-1:0] s1_s_q;
  logic [gain_bits-1:0]       s1_gain_q;
  logic [1:0]                 s1_mode_q;
  logic [fxp_size-2:0]        s1_thr_q;

  logic                       s2_valid_q, s2_chok_q;
  logic [CW-1:0]              s2_ch_q;
  logic signed [fxp_size-1:0] s2_s_q;
  logic signed [PW-1:0]       s2_p_q;
  logic [1:0]                 s2_mode_q;
  logic [fxp_size-2:0]        s2_thr_q;

  logic                       out_valid_q;
  logic [CW-1:0]              out_ch_q;
  logic [fxp_size-1:0]        out_sample_q;
  logic [channels-1:0]        sat_q, sat_d, sat_set;

  logic                       in_chok, cfg_ok;
  logic [gain_bits-1:0]       gain_rd;
  logic signed [fxp_size-1:0] s_in;
  logic signed [gain_bits:0]  gain_s;
  logic signed [PW-1:0]       prod;
  logic signed [fxp_size-1:0] sat_v, thr_pos, thr_neg, shaped;
  logic                       clamp;

  assign en      = !out_valid_q || i_ready;
  assign o_ready = en;
  assign o_valid = out_valid_q;
  assign o_channel = out_ch_q;
  assign o_sample  = out_sample_q;
  assign o_sat     = sat_q;

  assign in_chok = int'(i_channel) < channels;
  assign cfg_ok  = int'(i_cfg_ch) < channels;
  assign gain_rd = in_chok ? gain_q[i_channel] : GAIN_ONE;
  // Offset-binary to two's complement, left-aligned into the output word.
  assign s_in    = $signed(fxp_size'({~i_sample[bits_per_level-1], i_sample[bits_per_level-2:0]})
                           << (fxp_size - bits_per_level));
  assign gain_s  = $signed({1'b0, s1_gain_q});
  assign prod    = s1_s_q * gain_s;

  always_comb begin
    sat_v   = s2_p_q[fxp_size-1:0];
    clamp   = 1'b0;
    thr_pos = $signed({1'b0, s2_thr_q});
    thr_neg = -thr_pos;
    if (s2_p_q > P_MAX) begin
      sat_v = MAX_F;
      clamp = 1'b1;
    end else if (s2_p_q < P_MIN) begin
      sat_v = MIN_F;
      clamp = 1'b1;
    end
    if (s2_mode_q == 2'd2) begin
      if (sat_v > thr_pos) begin
        sat_v = thr_pos;
        clamp = 1'b1;
      end else if (sat_v < thr_neg) begin
        sat_v = thr_neg;
        clamp = 1'b1;
      end
    end
    shaped = sat_v;
    if (s2_mode_q == 2'd0) begin
      shaped = s2_s_q;
      clamp  = 1'b0;
    end
  end

  // A new clamp event on a channel outranks a simultaneous clear.
  always_comb begin
    sat_set = '0;
    if (en && s2_valid_q && s2_chok_q && clamp) sat_set[s2_ch_q] = 1'b1;
    sat_d = (i_sat_clr ? '0 : sat_q) | sat_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < channels; i++) gain_q[i] <= GAIN_ONE;
    end else if (i_cfg_we && cfg_ok) begin
      gain_q[i_cfg_ch] <= i_cfg_gain;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_chok_q  <= 1'b0;
      s1_ch_q    <= '0;
      s1_s_q     <= '0;
      s1_gain_q  <= '0;
      s1_mode_q  <= '0;
      s1_thr_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_chok_q  <= 1'b0;
      s2_ch_q    <= '0;
      s2_s_q     <= '0;
      s2_p_q     <= '0;
      s2_mode_q  <= '0;
      s2_thr_q   <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_sample_q <= '0;
      sat_q        <= '0;
    end else begin
      sat_q <= sat_d;
      if (en) begin
        s1_valid_q <= i_valid;
        if (i_valid) begin
          s1_chok_q <= in_chok;
          s1_ch_q   <= i_channel;
          s1_s_q    <= s_in;
          s1_gain_q <= gain_rd;
          s1_mode_q <= i_mode;
          s1_thr_q  <= i_clip_thr;
        end
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_chok_q <= s1_chok_q;
          s2_ch_q   <= s1_ch_q;
          s2_s_q    <= s1_s_q;
          s2_p_q    <= prod >>> bits_per_gain_frac;
          s2_mode_q <= s1_mode_q;
          s2_thr_q  <= s1_thr_q;
        end
        out_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          out_ch_q     <= s2_ch_q;
          out_sample_q <= shaped;
        end
      end
    end
  end

endmodule

// File: tb/tb_effects_pipeline_mc.sv
// Scoreboard bench for effects_pipeline_mc: driver pushes hand-computed expectations,
// a negedge monitor pops and compares on every output transfer.
module tb_effects_pipeline_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready, i_ready, o_valid;
  logic [0:0]  i_channel, o_channel, i_cfg_ch;
  logic [11:0] i_sample;
  logic [15:0] o_sample;
  logic        i_cfg_we;
  logic [10:0] i_cfg_gain;
  logic [1:0]  i_mode;
  logic [14:0] i_clip_thr;
  logic        i_sat_clr;
  logic [1:0]  o_sat;

  typedef struct packed {
    logic        ch;
    logic [15:0] s;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic        stall_prev = 1'b0;
  logic [15:0] held_s;
  logic        held_c;

  localparam logic [15:0] T4_EXP [8] = '{16'h0100, 16'h0400, 16'h0300, 16'h0800,
                                         16'h0500, 16'h0C00, 16'h0700, 16'h1000};

  always #5 clk = ~clk;

  effects_pipeline_mc dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .o_ready(o_ready), .i_channel(i_channel), .i_sample(i_sample),
    .o_valid(o_valid), .i_ready(i_ready), .o_channel(o_channel), .o_sample(o_sample),
    .i_cfg_we(i_cfg_we), .i_cfg_ch(i_cfg_ch), .i_cfg_gain(i_cfg_gain),
    .i_mode(i_mode), .i_clip_thr(i_clip_thr), .i_sat_clr(i_sat_clr), .o_sat(o_sat)
  );

  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!(o_valid && o_sample == held_s && o_channel == held_c)) begin
          errors++;
          $display("FAIL hold: got v=%0b ch=%0d s=%h, need v=1 ch=%0d s=%h",
                   o_valid, o_channel, o_sample, held_c, held_s);
        end
      end
      if (o_valid && !i_ready) begin
        checks++;
        if (o_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready: got o_ready=%0b, need 0", o_ready);
        end
        stall_prev = 1'b1;
        held_s = o_sample;
        held_c = o_channel;
      end else begin
        stall_prev = 1'b0;
      end
      if (o_valid && i_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got ch=%0d s=%h, need no output", o_channel, o_sample);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (o_channel !== e.ch || o_sample !== e.s) begin
            errors++;
            $display("FAIL out_data: got ch=%0d s=%h, need ch=%0d s=%h",
                     o_channel, o_sample, e.ch, e.s);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s: got %h, need %h", name, got, need);
    end
  endtask

  task automatic send(input logic ch, input logic [11:0] smp, input logic [1:0] mode,
                      input logic [14:0] thr, input logic [15:0] exp_s, input bit push);
    int budget = 0;
    i_valid = 1'b1; i_channel = ch; i_sample = smp; i_mode = mode; i_clip_thr = thr;
    @(negedge clk);
    while (!o_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got o_ready=0 for %0d cycles, need 1", budget);
    end else if (push) begin
      sb_q.push_back('{ch: ch, s: exp_s});
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (sb_q.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, need 0", sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic ch, input logic [10:0] g);
    i_cfg_we = 1'b1; i_cfg_ch = ch; i_cfg_gain = g;
    @(posedge clk); #1;
    i_cfg_we = 1'b0;
  endtask

  task automatic sat_clear();
    i_sat_clr = 1'b1;
    @(posedge clk); #1;
    i_sat_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, need finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_channel = '0; i_sample = '0;
    i_cfg_we = 1'b0; i_cfg_ch = '0; i_cfg_gain = '0; i_mode = 2'd1; i_clip_thr = '0;
    i_sat_clr = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_o_valid", 32'(o_valid), 32'd0);
    check("reset_o_sample", 32'(o_sample), 32'd0);
    check("reset_o_channel", 32'(o_channel), 32'd0);
    check("reset_o_sat", 32'(o_sat), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("reset_o_ready", 32'(o_ready), 32'd1);
    @(posedge clk); #1;

    // Unity gain, mode 1
    send(1'b0, 12'h800, 2'd1, 15'h0, 16'h0000, 1'b1);
    send(1'b0, 12'hC00, 2'd1, 15'h0, 16'h4000, 1'b1);
    send(1'b0, 12'h000, 2'd1, 15'h0, 16'h8000, 1'b1);
    drain();
    check("t1_sat", 32'(o_sat), 32'd0);

    // Gain 2.0 on ch1 saturates, then clear
    cfg_write(1'b1, 11'h020);
    send(1'b1, 12'hC00, 2'd1, 15'h0, 16'h7FFF, 1'b1);
    drain();
    check("t2_sat_set", 32'(o_sat), 32'd2);
    sat_clear();
    @(negedge clk);
    check("t2_sat_clr", 32'(o_sat), 32'd0);
    @(posedge clk); #1;

    // Bypass ignores gain; mode 3 behaves as mode 1
    send(1'b1, 12'hC00, 2'd0, 15'h0, 16'h4000, 1'b1);
    send(1'b0, 12'hC00, 2'd3, 15'h0, 16'h4000, 1'b1);
    drain();
    check("bypass_no_flag", 32'(o_sat), 32'd0);

    // Hard clip at 0x2000
    send(1'b0, 12'hC00, 2'd2, 15'h2000, 16'h2000, 1'b1);
    send(1'b0, 12'h400, 2'd2, 15'h2000, 16'hE000, 1'b1);
    send(1'b0, 12'h900, 2'd2, 15'h2000, 16'h1000, 1'b1);
    drain();
    check("t3_clip_flag", 32'(o_sat), 32'd1);
    sat_clear();

    // Alternating stream with a 4-cycle downstream stall
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(k[0], 12'h800 + 12'((k + 1) * 16), 2'd1, 15'h0, T4_EXP[k], 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        #1 i_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();
    check("t4_sat", 32'(o_sat), 32'd0);

    // Config write in the same cycle as a ch0 sample: old gain applies
    i_cfg_we = 1'b1; i_cfg_ch = 1'b0; i_cfg_gain = 11'h008;
    i_valid = 1'b1; i_channel = 1'b0; i_sample = 12'hC00; i_mode = 2'd1;
    @(negedge clk);
    check("t5_ready", 32'(o_ready), 32'd1);
    sb_q.push_back('{ch: 1'b0, s: 16'h4000});
    @(posedge clk); #1;
    i_cfg_we = 1'b0; i_valid = 1'b0;
    send(1'b0, 12'hC00, 2'd1, 15'h0, 16'h2000, 1'b1);
    drain();

    // Reset with samples in flight; nothing stale may come out
    send(1'b1, 12'hC00, 2'd1, 15'h0, 16'h0, 1'b0);
    send(1'b1, 12'hD00, 2'd1, 15'h0, 16'h0, 1'b0);
    send(1'b1, 12'hE00, 2'd1, 15'h0, 16'h0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("t6_valid_in_rst", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t6_ready_after", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    send(1'b1, 12'hC00, 2'd1, 15'h0, 16'h4000, 1'b1);
    send(1'b0, 12'hC00, 2'd1, 15'h0, 16'h4000, 1'b1);
    drain();
    check("t6_sat", 32'(o_sat), 32'd0);

    repeat (5) @(posedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
